// File: rtl/leg_wb_pkg.sv
// Shared types and helpers for the LEG write-back stage.
// Write-back entries carry a destination, result data and a write flag.
package leg_wb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int WB_DATA_W  = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0]  data;
    logic                  wr;
  } wb_entry_t;

  // Select bits are LSB first: bit 0 drives decoder input 1.
  function automatic logic [3:0] dest_to_bits(input logic [REG_ADDR_W-1:0] dest);
    return {dest[3], dest[2], dest[1], dest[0]};
  endfunction

endpackage

// File: rtl/leg_wb_fifo.sv
// Small synchronous FIFO of write-back entries with full/empty/count status.
// Pointers wrap modulo DEPTH; count is one bit wider than the pointers.
module leg_wb_fifo
  import leg_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                wdata,
  input  logic                     pop,
  output wb_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leg_wb_stage.sv
// LEG write-back stage: result FIFO, registered decoder drive, pending-write scoreboard.
// Optional LEG_WB_BYPASS_EN sends a push into an empty, unstalled stage straight to the outputs.
module leg_wb_stage
  import leg_wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_dest,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_wr,
  input  logic                  wb_stall,
  input  logic                  issue_valid,
  input  logic [3:0]            issue_dest,
  output logic                  dec_bit1,
  output logic                  dec_bit2,
  output logic                  dec_bit3,
  output logic                  dec_bit4,
  output logic                  dec_disable,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [15:0]           pending
);

  wb_entry_t              in_entry;
  wb_entry_t              head_entry;
  wb_entry_t              retire_entry;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   push;
  logic                   fifo_push;
  logic                   pop;
  logic                   bypass;
  logic                   retire;
  logic [3:0]             out_dest;
  logic [3:0]             sel_bits;
  logic [15:0]            pending_next;

  assign in_entry  = '{dest: in_dest, data: in_data, wr: in_wr};
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = !fifo_empty && !wb_stall;

`ifdef LEG_WB_BYPASS_EN
  assign bypass    = push && fifo_empty && !wb_stall;
`else
  assign bypass    = 1'b0;
`endif

  assign fifo_push    = push && !bypass;
  assign retire       = pop || bypass;
  assign retire_entry = pop ? head_entry : in_entry;

  leg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  empty_matches_count: assert property (@(posedge clk) disable iff (rst)
    fifo_empty == (fifo_count == '0));

  // A retiring entry loads the decoder registers; any idle edge only re-disables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dest    <= '0;
      wr_data     <= '0;
      dec_disable <= 1'b1;
    end else if (retire) begin
      out_dest    <= retire_entry.dest;
      wr_data     <= retire_entry.data;
      dec_disable <= !retire_entry.wr;
    end else begin
      dec_disable <= 1'b1;
    end
  end

  assign sel_bits = dest_to_bits(out_dest);
  assign dec_bit1 = sel_bits[0];
  assign dec_bit2 = sel_bits[1];
  assign dec_bit3 = sel_bits[2];
  assign dec_bit4 = sel_bits[3];

  // Set is applied after clear so a newer producer keeps its register marked.
  always_comb begin
    pending_next = pending;
    if (retire && retire_entry.wr) pending_next[retire_entry.dest] = 1'b0;
    if (issue_valid)               pending_next[issue_dest]        = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

endmodule

// File: tb/tb_leg_wb_stage.sv
// Self-checking bench for leg_wb_stage: directed scenarios plus random traffic
// compared against a queue-based model of the write-back rules.
module tb_leg_wb_stage;

  localparam int DEPTH = 2;
  localparam int DW    = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_dest;
  logic [DW-1:0] in_data;
  logic          in_wr;
  logic          wb_stall;
  logic          issue_valid;
  logic [3:0]    issue_dest;
  logic          dec_bit1, dec_bit2, dec_bit3, dec_bit4;
  logic          dec_disable;
  logic [DW-1:0] wr_data;
  logic [15:0]   pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]    dest;
    logic [DW-1:0] data;
    logic          wr;
  } ent_t;

  ent_t          m_q[$];
  logic [15:0]   m_pending;
  logic          m_disable;
  logic [3:0]    m_dest;
  logic [DW-1:0] m_data;

  leg_wb_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_data     (in_data),
    .in_wr       (in_wr),
    .wb_stall    (wb_stall),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .dec_bit1    (dec_bit1),
    .dec_bit2    (dec_bit2),
    .dec_bit3    (dec_bit3),
    .dec_bit4    (dec_bit4),
    .dec_disable (dec_disable),
    .wr_data     (wr_data),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".in_ready"}, 32'(in_ready), 32'(m_q.size() < DEPTH));
    checkOutput({where, ".dec_bits"}, 32'({dec_bit4, dec_bit3, dec_bit2, dec_bit1}), 32'(m_dest));
    checkOutput({where, ".dec_disable"}, 32'(dec_disable), 32'(m_disable));
    checkOutput({where, ".wr_data"}, 32'(wr_data), 32'(m_data));
    checkOutput({where, ".pending"}, 32'(pending), 32'(m_pending));
  endtask

  // One clock edge of the reference behaviour, using the inputs held across that edge.
  task automatic modelEdge(input logic v, input logic [3:0] d, input logic [DW-1:0] dat,
                           input logic w, input logic st, input logic iv, input logic [3:0] id);
    ent_t incoming;
    ent_t r;
    logic accepted;
    logic retired;
    incoming = '{dest: d, data: dat, wr: w};
    accepted = v && (m_q.size() < DEPTH);
    retired  = 1'b0;
    if (m_q.size() > 0 && !st) begin
      r = m_q.pop_front();
      retired = 1'b1;
      if (accepted) m_q.push_back(incoming);
    end else if (accepted) begin
`ifdef LEG_WB_BYPASS_EN
      if (!st && m_q.size() == 0) begin
        r = incoming;
        retired = 1'b1;
      end else begin
        m_q.push_back(incoming);
      end
`else
      m_q.push_back(incoming);
`endif
    end
    if (retired) begin
      m_dest    = r.dest;
      m_data    = r.data;
      m_disable = !r.wr;
      if (r.wr) m_pending[r.dest] = 1'b0;
    end else begin
      m_disable = 1'b1;
    end
    if (iv) m_pending[id] = 1'b1;
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [3:0] d,
                               input logic [DW-1:0] dat, input logic w, input logic st,
                               input logic iv, input logic [3:0] id);
    @(negedge clk);
    in_valid    = v;
    in_dest     = d;
    in_data     = dat;
    in_wr       = w;
    wb_stall    = st;
    issue_valid = iv;
    issue_dest  = id;
    @(posedge clk);
    modelEdge(v, d, dat, w, st, iv, id);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // Reset is raised mid-cycle and must clear outputs without waiting for an edge.
  task automatic resetDut(input string tag);
    @(negedge clk);
    in_valid = 1'b0; wb_stall = 1'b0; issue_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_q.delete();
    m_pending = '0;
    m_disable = 1'b1;
    m_dest    = '0;
    m_data    = '0;
    checkOutput({tag, ".rst_disable"}, 32'(dec_disable), 32'd1);
    checkOutput({tag, ".rst_pending"}, 32'(pending), 32'h0);
    checkOutput({tag, ".rst_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, ".rst_bits"}, 32'({dec_bit4, dec_bit3, dec_bit2, dec_bit1}), 32'h0);
    checkOutput({tag, ".rst_data"}, 32'(wr_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_dest = '0; in_data = '0; in_wr = 1'b0;
    wb_stall = 1'b0; issue_valid = 1'b0; issue_dest = '0;
    m_q.delete(); m_pending = '0; m_disable = 1'b1; m_dest = '0; m_data = '0;

    $display("[TB] reset and idle");
    resetDut("reset");
    for (int i = 0; i < 5; i++) idle("idle");

    $display("[TB] single write");
    applyStimulus("issue5", 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b1, 4'd5);
    checkOutput("pending_after_issue5", 32'(pending), 32'h0020);
    applyStimulus("push5", 1'b1, 4'd5, 8'hA3, 1'b1, 1'b0, 1'b0, 4'h0);
    idle("pop5");
    idle("after5");
    checkOutput("pending_cleared5", 32'(pending), 32'h0000);

    $display("[TB] back-pressure");
    applyStimulus("bp_push1", 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 1'b0, 4'h0);
    applyStimulus("bp_push2", 1'b1, 4'd2, 8'h22, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("bp_ready_low", 32'(in_ready), 32'd0);
    applyStimulus("bp_hold3", 1'b1, 4'd3, 8'h33, 1'b1, 1'b1, 1'b0, 4'h0);
    applyStimulus("bp_rel1", 1'b1, 4'd3, 8'h33, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus("bp_rel2", 1'b1, 4'd3, 8'h33, 1'b1, 1'b0, 1'b0, 4'h0);
    idle("bp_rel3");
    idle("bp_drain");

    $display("[TB] non-writing retire");
    applyStimulus("issue7", 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b1, 4'd7);
    applyStimulus("push7", 1'b1, 4'd7, 8'h77, 1'b0, 1'b0, 1'b0, 4'h0);
    idle("pop7");
    idle("after7");
    checkOutput("pending7_kept", 32'(pending[7]), 32'd1);

    $display("[TB] scoreboard race");
    applyStimulus("push9", 1'b1, 4'd9, 8'h99, 1'b1, 1'b1, 1'b1, 4'd9);
    applyStimulus("race9", 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b1, 4'd9);
    checkOutput("pending9_set_wins", 32'(pending[9]), 32'd1);
    idle("after9");

    $display("[TB] latency");
    applyStimulus("push15", 1'b1, 4'd15, 8'h01, 1'b1, 1'b0, 1'b0, 4'h0);
`ifdef LEG_WB_BYPASS_EN
    checkOutput("lat_edge1_disable", 32'(dec_disable), 32'd0);
`else
    checkOutput("lat_edge1_disable", 32'(dec_disable), 32'd1);
`endif
    idle("lat_edge2");
    idle("lat_edge3");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) resetDut("rand_reset");
      applyStimulus("rand",
                    logic'($urandom_range(0, 9) < 7),
                    4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)),
                    logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 9) < 3),
                    4'($urandom_range(0, 15)));
    end

    $display("[TB] reset with full FIFO");
    applyStimulus("full_a", 1'b1, 4'd4, 8'h44, 1'b1, 1'b1, 1'b0, 4'h0);
    applyStimulus("full_b", 1'b1, 4'd6, 8'h66, 1'b1, 1'b1, 1'b0, 4'h0);
    resetDut("full_reset");
    idle("post_reset1");
    idle("post_reset2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leg_wb_stage.md
Name: leg_wb_stage

Overview:
Write-back stage of the LEG core, sitting directly upstream of the 4-bit register-select decoder.
- Buffers completed results from ALU and memory in a small FIFO.
- Retires one result per cycle by driving the decoder's four select bits and active-high disable, plus the write data for the register bank.
- Keeps a 16-bit pending-write scoreboard so issue logic can detect RAW hazards.

Parameters:
DATA_WIDTH, 8, width of result data and of wr_data.
DEPTH, 2, FIFO entries; legal values are 2 and 4.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  result offered by the execute stage.
in_ready  out  1  stage can accept; equals FIFO not full.
in_dest  in  4  destination register index.
in_data  in  DATA_WIDTH  result value.
in_wr  in  1  1 = result writes a register; 0 = retire without a write (CMP, branch).
wb_stall  in  1  holds retirement; the FIFO keeps its contents.
issue_valid  in  1  an instruction with a register destination is issuing this cycle.
issue_dest  in  4  destination of the issuing instruction.
dec_bit1..dec_bit4  out  1 each  decoder select, LSB first (bit1 = dest[0]).
dec_disable  out  1  1 = no register write this cycle.
wr_data  out  DATA_WIDTH  data for the selected register.
pending  out  16  bit r set means a write to register r is outstanding.

Behaviour:
Reset, asynchronous, takes effect immediately:
- FIFO empty; in_ready=1.
- dec_bit1..4=0, dec_disable=1, wr_data=0, pending=0.

Push: an entry is pushed on a clock edge when in_valid and in_ready are both 1. in_ready is registered and equals !full. Push and pop in the same cycle are both honoured.

Pop: on a clock edge where the FIFO is non-empty and wb_stall=0, the head is popped.
- Output registers load dest, data, and dec_disable = !wr.
- On every other edge, dec_disable<=1; dec_bit* and wr_data hold their previous values.
- Outputs are registered, so dec_disable=0 lasts exactly one cycle per write.

Latency (bypass compiled out): accepted at edge E0, popped at E1, decoder driven during the cycle after E1.

Ordering: strict FIFO order. No coalescing of writes to the same register.

Scoreboard:
- issue_valid sets pending[issue_dest] on the edge.
- A pop with wr=1 clears pending[dest] on the same edge.
- Set and clear of the same index on the same edge: set wins, because a newer producer exists.
- Pops with wr=0 never touch pending.

wb_stall asserted mid-stream: the head stays put, dec_disable=1, pushes continue until full.

Reset during a stall or with a full FIFO discards every entry. No write is emitted afterwards.

Pointer arithmetic wraps modulo DEPTH. Count width is clog2(DEPTH)+1.

Optional Feature:
LEG_WB_BYPASS_EN
- Defined: when the FIFO is empty, wb_stall=0 and a push occurs, the entry goes straight to the output registers on the same edge and is not stored. Latency is one edge. The scoreboard clear applies on that same edge.
- Undefined: every entry passes through the FIFO, with the 2-edge latency above.

Decomposition:
Shared package leg_wb_pkg contains:
- REG_ADDR_W=4, NUM_REGS=16.
- typedef wb_entry_t {dest[3:0], data[DATA_WIDTH-1:0], wr}.
- Function dest_to_bits splitting dest into the four select bits.

One sub-module, leg_wb_fifo: parameterised synchronous FIFO of wb_entry_t with full, empty and count outputs, and asynchronous active-high reset. The scoreboard and output registers stay in leg_wb_stage.

Test Plan:
1. Reset then idle: assert rst mid-cycle -> outputs clear immediately; dec_disable=1, pending=0, in_ready=1 for 5 cycles.
2. Single write: issue_dest=5 -> pending=0x0020. Push dest=5, data=0xA3, wr=1 -> two edges later bits4..1=0101, wr_data=0xA3, dec_disable=0 for one cycle, then 1; pending=0x0000 on the pop edge.
3. Back-pressure: wb_stall=1, push 3 entries with DEPTH=2 -> in_ready=0 after the second push and the third is held. Release stall -> writes to dest 1, 2, 3 in order on consecutive cycles.
4. Non-writing retire: push dest=7, wr=0 with pending[7]=1 -> dec_disable stays 1 and pending[7] stays 1.
5. Scoreboard race: pop a write to r9 on the same edge as issue_valid, issue_dest=9 -> pending[9]=1.
6. Bypass (LEG_WB_BYPASS_EN defined): empty FIFO, push dest=15, data=0x01 -> after one edge bits=1111, dec_disable=0. Without the macro the same stimulus appears one edge later.
